// File: rtl/irda_fir_rx_fifo.sv
// rtl/irda_fir_rx_fifo.sv - FIR receive data FIFO (FWFT) with optional per-frame status queue
// Status queue, stop-edge detector and frame word counter exist only with IRDA_FIR_RX_STATUS_EN.
module irda_fir_rx_fifo #(
  parameter int RF_AW = 4,
  parameter int ST_AW = 2
) (
  input  logic               clk,
  input  logic               wb_rst_i,
  input  logic               rf_flush,
  input  logic               rx_restart,
  input  logic               rxfifo_add,
  input  logic [31:0]        rxfifo_dat_i,
  input  logic               fir_sto_detected,
  input  logic               crc32_error,
  input  logic [15:0]        fir_ifdlr_i,
  input  logic               rf_pop,
  output logic [31:0]        rf_dat_o,
  output logic               rf_empty,
  output logic               rf_full,
  output logic [RF_AW:0]     rf_count_o,
  output logic               rf_overrun,
  input  logic               st_pop,
  output logic               st_valid,
  output logic [15:0]        st_len_o,
  output logic [15:0]        st_words_o,
  output logic               st_crc_err_o,
  output logic               st_overrun
);

  localparam int RF_DEPTH = 1 << RF_AW;
  localparam logic [RF_AW:0] RF_FULL_CNT = {1'b1, {RF_AW{1'b0}}};

  logic [31:0]      rf_mem_q [RF_DEPTH];
  logic [RF_AW-1:0] rf_wr_q, rf_wr_d, rf_rd_q, rf_rd_d;
  logic [RF_AW:0]   rf_cnt_q, rf_cnt_d;
  logic             rf_ovr_q, rf_ovr_d;
  logic             rf_is_empty, rf_is_full, rf_push_ok, rf_pop_ok;

  // A push into a full FIFO is still accepted when a pop frees the head in the same cycle.
  always_comb begin
    rf_is_empty = (rf_cnt_q == '0);
    rf_is_full  = (rf_cnt_q == RF_FULL_CNT);
    rf_pop_ok   = rf_pop && !rf_is_empty;
    rf_push_ok  = rxfifo_add && (!rf_is_full || rf_pop);
    rf_wr_d     = rf_wr_q;
    rf_rd_d     = rf_rd_q;
    rf_cnt_d    = rf_cnt_q;
    rf_ovr_d    = rf_ovr_q;
    if (rf_push_ok) rf_wr_d = rf_wr_q + RF_AW'(1);
    if (rf_pop_ok)  rf_rd_d = rf_rd_q + RF_AW'(1);
    if (rf_push_ok && !rf_pop_ok)      rf_cnt_d = rf_cnt_q + (RF_AW+1)'(1);
    else if (!rf_push_ok && rf_pop_ok) rf_cnt_d = rf_cnt_q - (RF_AW+1)'(1);
    if (rxfifo_add && !rf_push_ok) rf_ovr_d = 1'b1;
    if (rf_flush) begin
      rf_wr_d  = '0;
      rf_rd_d  = '0;
      rf_cnt_d = '0;
      rf_ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      rf_wr_q  <= '0;
      rf_rd_q  <= '0;
      rf_cnt_q <= '0;
      rf_ovr_q <= 1'b0;
    end else begin
      rf_wr_q  <= rf_wr_d;
      rf_rd_q  <= rf_rd_d;
      rf_cnt_q <= rf_cnt_d;
      rf_ovr_q <= rf_ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!wb_rst_i && !rf_flush && rf_push_ok) rf_mem_q[rf_wr_q] <= rxfifo_dat_i;
  end

  assign rf_dat_o   = rf_is_empty ? 32'h0 : rf_mem_q[rf_rd_q];
  assign rf_empty   = rf_is_empty;
  assign rf_full    = rf_is_full;
  assign rf_count_o = rf_cnt_q;
  assign rf_overrun = rf_ovr_q;

`ifdef IRDA_FIR_RX_STATUS_EN
  localparam int ST_DEPTH = 1 << ST_AW;
  localparam logic [ST_AW:0] ST_FULL_CNT = {1'b1, {ST_AW{1'b0}}};

  logic [15:0]      st_len_mem_q   [ST_DEPTH];
  logic [15:0]      st_words_mem_q [ST_DEPTH];
  logic             st_crc_mem_q   [ST_DEPTH];
  logic [ST_AW-1:0] st_wr_q, st_wr_d, st_rd_q, st_rd_d;
  logic [ST_AW:0]   st_cnt_q, st_cnt_d;
  logic             st_ovr_q, st_ovr_d;
  logic             sto_q, sto_d;
  logic [15:0]      word_cnt_q, word_cnt_d;
  logic [15:0]      cap_words;
  logic             sto_evt, st_is_empty, st_is_full, st_pop_ok, st_cap_ok;

  // cap_words folds in a push accepted in the capture cycle so the record counts it.
  always_comb begin
    sto_evt     = fir_sto_detected && !sto_q;
    st_is_empty = (st_cnt_q == '0);
    st_is_full  = (st_cnt_q == ST_FULL_CNT);
    st_pop_ok   = st_pop && !st_is_empty;
    st_cap_ok   = sto_evt && (!st_is_full || st_pop);
    cap_words   = (rf_push_ok && (word_cnt_q != 16'hFFFF)) ? word_cnt_q + 16'd1 : word_cnt_q;
    sto_d       = fir_sto_detected;
    st_wr_d     = st_wr_q;
    st_rd_d     = st_rd_q;
    st_cnt_d    = st_cnt_q;
    st_ovr_d    = st_ovr_q;
    word_cnt_d  = cap_words;
    if (st_cap_ok) st_wr_d = st_wr_q + ST_AW'(1);
    if (st_pop_ok) st_rd_d = st_rd_q + ST_AW'(1);
    if (st_cap_ok && !st_pop_ok)      st_cnt_d = st_cnt_q + (ST_AW+1)'(1);
    else if (!st_cap_ok && st_pop_ok) st_cnt_d = st_cnt_q - (ST_AW+1)'(1);
    if (sto_evt && !st_cap_ok) st_ovr_d = 1'b1;
    if (rx_restart || sto_evt) word_cnt_d = 16'h0;
    if (rf_flush) begin
      sto_d      = 1'b0;
      st_wr_d    = '0;
      st_rd_d    = '0;
      st_cnt_d   = '0;
      st_ovr_d   = 1'b0;
      word_cnt_d = 16'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      sto_q      <= 1'b0;
      st_wr_q    <= '0;
      st_rd_q    <= '0;
      st_cnt_q   <= '0;
      st_ovr_q   <= 1'b0;
      word_cnt_q <= 16'h0;
    end else begin
      sto_q      <= sto_d;
      st_wr_q    <= st_wr_d;
      st_rd_q    <= st_rd_d;
      st_cnt_q   <= st_cnt_d;
      st_ovr_q   <= st_ovr_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!wb_rst_i && !rf_flush && st_cap_ok) begin
      st_len_mem_q[st_wr_q]   <= fir_ifdlr_i;
      st_words_mem_q[st_wr_q] <= cap_words;
      st_crc_mem_q[st_wr_q]   <= crc32_error;
    end
  end

  assign st_valid     = !st_is_empty;
  assign st_len_o     = st_is_empty ? 16'h0 : st_len_mem_q[st_rd_q];
  assign st_words_o   = st_is_empty ? 16'h0 : st_words_mem_q[st_rd_q];
  assign st_crc_err_o = st_is_empty ? 1'b0  : st_crc_mem_q[st_rd_q];
  assign st_overrun   = st_ovr_q;
`else
  logic unused_status_inputs;
  assign unused_status_inputs = ^{rx_restart, fir_sto_detected, crc32_error, fir_ifdlr_i, st_pop};

  assign st_valid     = 1'b0;
  assign st_len_o     = 16'h0;
  assign st_words_o   = 16'h0;
  assign st_crc_err_o = 1'b0;
  assign st_overrun   = 1'b0;
`endif

endmodule

// File: tb/tb_irda_fir_rx_fifo.sv
// tb/tb_irda_fir_rx_fifo.sv - scoreboard bench for irda_fir_rx_fifo
// Status checks follow IRDA_FIR_RX_STATUS_EN; otherwise status outputs must stay 0.
module tb_irda_fir_rx_fifo;
  localparam int RF_AW = 4;
  localparam int ST_AW = 2;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b0, rf_flush = 1'b0, rx_restart = 1'b0;
  logic        rxfifo_add = 1'b0;
  logic [31:0] rxfifo_dat_i = '0;
  logic        fir_sto_detected = 1'b0, crc32_error = 1'b0;
  logic [15:0] fir_ifdlr_i = '0;
  logic        rf_pop = 1'b0, st_pop = 1'b0;
  logic [31:0] rf_dat_o;
  logic        rf_empty, rf_full, rf_overrun;
  logic [RF_AW:0] rf_count_o;
  logic        st_valid, st_crc_err_o, st_overrun;
  logic [15:0] st_len_o, st_words_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_data[$];
  logic [32:0] exp_st[$];

  always #5 clk = ~clk;

  irda_fir_rx_fifo #(.RF_AW(RF_AW), .ST_AW(ST_AW)) dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .rf_flush(rf_flush), .rx_restart(rx_restart),
    .rxfifo_add(rxfifo_add), .rxfifo_dat_i(rxfifo_dat_i),
    .fir_sto_detected(fir_sto_detected), .crc32_error(crc32_error), .fir_ifdlr_i(fir_ifdlr_i),
    .rf_pop(rf_pop), .rf_dat_o(rf_dat_o), .rf_empty(rf_empty), .rf_full(rf_full),
    .rf_count_o(rf_count_o), .rf_overrun(rf_overrun),
    .st_pop(st_pop), .st_valid(st_valid), .st_len_o(st_len_o), .st_words_o(st_words_o),
    .st_crc_err_o(st_crc_err_o), .st_overrun(st_overrun)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares the head presented on each honoured pop against the scoreboard.
  always @(negedge clk) begin
    if (!wb_rst_i && !rf_flush && rf_pop && !rf_empty) begin
      checks++;
      if (exp_data.size() == 0) begin
        errors++;
        $display("FAIL rf_extra_word: got %0h expected none", rf_dat_o);
      end else begin
        logic [31:0] e;
        e = exp_data.pop_front();
        if (rf_dat_o !== e) begin
          errors++;
          $display("FAIL rf_dat_o: got %0h expected %0h", rf_dat_o, e);
        end
      end
    end
    if (!wb_rst_i && !rf_flush && st_pop && st_valid) begin
      checks++;
      if (exp_st.size() == 0) begin
        errors++;
        $display("FAIL st_extra_record: got %0h expected none", {st_len_o, st_words_o, st_crc_err_o});
      end else begin
        logic [32:0] r;
        r = exp_st.pop_front();
        if ({st_len_o, st_words_o, st_crc_err_o} !== r) begin
          errors++;
          $display("FAIL st_record: got %0h expected %0h", {st_len_o, st_words_o, st_crc_err_o}, r);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    rxfifo_add = 1'b0;
    rf_pop     = 1'b0;
    st_pop     = 1'b0;
    rf_flush   = 1'b0;
    wb_rst_i   = 1'b0;
    rx_restart = 1'b0;
  endtask

  task automatic push(input logic [31:0] w);
    rxfifo_add = 1'b1;
    rxfifo_dat_i = w;
    exp_data.push_back(w);
    step();
  endtask

  task automatic pop();
    rf_pop = 1'b1;
    step();
  endtask

  task automatic flush();
    rf_flush = 1'b1;
    exp_data.delete();
    exp_st.delete();
    step();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_count"}, 64'(rf_count_o), 64'd0);
    chk({tag, "_empty"}, 64'(rf_empty), 64'd1);
    chk({tag, "_full"}, 64'(rf_full), 64'd0);
    chk({tag, "_ovr"}, 64'(rf_overrun), 64'd0);
    chk({tag, "_dat"}, 64'(rf_dat_o), 64'd0);
    chk({tag, "_st"}, 64'({st_valid, st_overrun, st_len_o, st_words_o, st_crc_err_o}), 64'd0);
  endtask

  initial begin
    wb_rst_i = 1'b1;
    step();
    check_idle("reset");

    // Three words in, three out; count 1,2,3 then 2,1,0.
    push(32'h11111111);
    chk("fwft_first", 64'(rf_dat_o), 64'h11111111);
    chk("cnt_p1", 64'(rf_count_o), 64'd1);
    push(32'h22222222);
    chk("cnt_p2", 64'(rf_count_o), 64'd2);
    push(32'h33333333);
    chk("cnt_p3", 64'(rf_count_o), 64'd3);
    pop();
    chk("cnt_q2", 64'(rf_count_o), 64'd2);
    pop();
    chk("cnt_q1", 64'(rf_count_o), 64'd1);
    pop();
    chk("cnt_q0", 64'(rf_count_o), 64'd0);
    chk("empty_end", 64'(rf_empty), 64'd1);
    rf_pop = 1'b1;
    step();
    chk("pop_empty_ovr", 64'(rf_overrun), 64'd0);

    // Fill to 16, drop the 17th.
    for (int i = 1; i <= 16; i++) begin
      push(32'hA000_0000 + 32'(i));
      if (i == 15) chk("not_full_15", 64'(rf_full), 64'd0);
    end
    chk("full_16", 64'(rf_full), 64'd1);
    chk("cnt_16", 64'(rf_count_o), 64'd16);
    chk("no_ovr_16", 64'(rf_overrun), 64'd0);
    rxfifo_add = 1'b1;
    rxfifo_dat_i = 32'hDEAD0017;
    step();
    chk("ovr_17", 64'(rf_overrun), 64'd1);
    chk("cnt_17", 64'(rf_count_o), 64'd16);
    for (int i = 0; i < 16; i++) pop();
    chk("drained", 64'(rf_empty), 64'd1);
    chk("ovr_sticky", 64'(rf_overrun), 64'd1);
    flush();
    check_idle("flush");

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 16; i++) push(32'hC000_0000 + 32'(i));
    rf_pop = 1'b1;
    push(32'hBBBBBBBB);
    chk("pp_full_cnt", 64'(rf_count_o), 64'd16);
    chk("pp_full_ovr", 64'(rf_overrun), 64'd0);
    chk("pp_full_full", 64'(rf_full), 64'd1);
    for (int i = 0; i < 16; i++) pop();
    chk("pp_drained", 64'(rf_count_o), 64'd0);
    rf_pop = 1'b1;
    push(32'h44444444);
    chk("pp_empty_cnt", 64'(rf_count_o), 64'd1);
    chk("pp_empty_dat", 64'(rf_dat_o), 64'h44444444);
    flush();

`ifdef IRDA_FIR_RX_STATUS_EN
    // 5 words, stop flag held 8 clocks: exactly one record.
    for (int i = 0; i < 5; i++) push(32'h5000_0000 + 32'(i));
    fir_sto_detected = 1'b1;
    fir_ifdlr_i = 16'h0014;
    crc32_error = 1'b0;
    exp_st.push_back({16'h0014, 16'd5, 1'b0});
    step();
    chk("st_valid_n1", 64'(st_valid), 64'd1);
    chk("st_words_5", 64'(st_words_o), 64'd5);
    for (int i = 0; i < 7; i++) step();
    fir_sto_detected = 1'b0;
    step();
    st_pop = 1'b1;
    step();
    chk("one_record", 64'(st_valid), 64'd0);

    // Next frame: 2 words, then stop edge coinciding with a 3rd push.
    push(32'h60000001);
    push(32'h60000002);
    fir_sto_detected = 1'b1;
    fir_ifdlr_i = 16'h0033;
    crc32_error = 1'b1;
    exp_st.push_back({16'h0033, 16'd3, 1'b1});
    push(32'h60000003);
    fir_sto_detected = 1'b0;
    step();
    st_pop = 1'b1;
    step();
    chk("rec2_popped", 64'(st_valid), 64'd0);
    flush();

    // Five stop events into a 4-deep queue.
    for (int i = 1; i <= 5; i++) begin
      fir_sto_detected = 1'b1;
      fir_ifdlr_i = 16'(i);
      crc32_error = i[0];
      if (i <= 4) exp_st.push_back({16'(i), 16'd0, i[0]});
      step();
      fir_sto_detected = 1'b0;
      step();
      if (i == 4) chk("st_ovr_4", 64'(st_overrun), 64'd0);
    end
    chk("st_ovr_5", 64'(st_overrun), 64'd1);
    for (int i = 0; i < 4; i++) begin
      st_pop = 1'b1;
      step();
    end
    chk("st_drained", 64'(st_valid), 64'd0);
    chk("st_ovr_sticky", 64'(st_overrun), 64'd1);
    flush();
    chk("st_ovr_flush", 64'(st_overrun), 64'd0);
`else
    for (int i = 0; i < 3; i++) push(32'h5000_0000 + 32'(i));
    fir_sto_detected = 1'b1;
    fir_ifdlr_i = 16'h0014;
    crc32_error = 1'b1;
    st_pop = 1'b1;
    step();
    fir_sto_detected = 1'b0;
    step();
    chk("st_tied", 64'({st_valid, st_overrun, st_len_o, st_words_o, st_crc_err_o}), 64'd0);
    chk("data_unaffected", 64'(rf_count_o), 64'd3);
    flush();
`endif

    // Reset mid-frame with 6 words queued.
    for (int i = 0; i < 6; i++) push(32'h7000_0000 + 32'(i));
    chk("pre_rst_cnt", 64'(rf_count_o), 64'd6);
    wb_rst_i = 1'b1;
    exp_data.delete();
    exp_st.delete();
    step();
    check_idle("midrst");
    push(32'h77777777);
    chk("post_rst_cnt", 64'(rf_count_o), 64'd1);
    chk("post_rst_dat", 64'(rf_dat_o), 64'h77777777);
`ifdef IRDA_FIR_RX_STATUS_EN
    fir_sto_detected = 1'b1;
    fir_ifdlr_i = 16'h0008;
    crc32_error = 1'b0;
    exp_st.push_back({16'h0008, 16'd1, 1'b0});
    step();
    fir_sto_detected = 1'b0;
    st_pop = 1'b1;
    step();
`endif
    pop();
    chk("final_empty", 64'(rf_empty), 64'd1);
    chk("sb_data_left", 64'(exp_data.size()), 64'd0);
    chk("sb_st_left", 64'(exp_st.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irda_fir_rx_fifo.md
# irda_fir_rx_fifo

Receive-side buffer directly downstream of the FIR receiver: accepts the 32-bit words pushed by the FIR receiver (`rxfifo_add`/`rxfifo_dat_i`) and holds them for the register/Wishbone side. It also records per-frame status (bit-length, word count, CRC result) at each stop-flag event in a small status queue. The host pops data words and status records independently. Overruns are flagged sticky.

## Interface
- `RF_AW`, 4, data FIFO address width; depth = 2^RF_AW words
- `ST_AW`, 2, status queue address width; depth = 2^ST_AW records

- `clk`  in  1  system clock
- `wb_rst_i`  in  1  reset, synchronous, active-high
- `rf_flush`  in  1  clears both queues, counters and sticky flags
- `rx_restart`  in  1  receiver restart; clears the in-progress frame word counter only
- `rxfifo_add`  in  1  push strobe, one `clk` per word
- `rxfifo_dat_i`  in  32  word to push
- `fir_sto_detected`  in  1  stop flag seen; level held several `clk`
- `crc32_error`  in  1  CRC result of the frame just ended
- `fir_ifdlr_i`  in  16  received bit-length/8 of current frame
- `rf_pop`  in  1  pop head data word
- `rf_dat_o`  out  32  head data word, valid when `rf_empty`=0
- `rf_empty`  out  1  data FIFO empty
- `rf_full`  out  1  data FIFO full
- `rf_count_o`  out  RF_AW+1  words held, 0..2^RF_AW
- `rf_overrun`  out  1  sticky: push attempted while full
- `st_pop`  in  1  pop head status record
- `st_valid`  out  1  status queue non-empty
- `st_len_o`  out  16  head record: `fir_ifdlr_i` at capture
- `st_words_o`  out  16  head record: words pushed in that frame
- `st_crc_err_o`  out  1  head record: `crc32_error` at capture
- `st_overrun`  out  1  sticky: stop event while status queue full

## Operation
- Priority per cycle: `wb_rst_i` > `rf_flush` > normal operation.
- Reset and flush give identical results: pointers 0, `rf_count_o`=0, `rf_empty`=1, `rf_full`=0, both overrun flags 0, `st_valid`=0, frame word counter 0, STO edge register 0. All head outputs read 0 while their queue is empty.
- Push: `rxfifo_add`=1 and not full writes `rxfifo_dat_i` at the write pointer. Write pointer increments modulo depth.
  - Push while full drops the word and sets `rf_overrun`.
- Pop: `rf_pop`=1 and not empty advances the read pointer modulo depth. `rf_pop` while empty is ignored (no flag).
- Simultaneous push and pop:
  - Not empty: both happen; count unchanged.
  - Full: both succeed; no overrun.
  - Empty: push only.
- Frame word counter increments on each accepted push. It saturates at 16'hFFFF and clears on `rx_restart` or after a status capture.
  - Dropped words are not counted.
  - If a push coincides with `rx_restart`, the counter clears and that word is not counted.
- Stop event is the rising edge of `fir_sto_detected`, found against a registered copy of the input. One event per frame, however long the level is held.
- On a stop event, the block writes the record {`fir_ifdlr_i`, word counter + (accepted push in the same cycle ? 1 : 0), `crc32_error`} into the status queue.
  - Queue full: the record is dropped, `st_overrun` is set, and the word counter still clears.
- `st_pop` behaves like `rf_pop`. Simultaneous capture and pop are both honoured, including when the queue is full.
- Sticky flags clear only on reset or `rf_flush`.

## Timing
- Data FIFO is first-word-fall-through. A word pushed in cycle N appears on `rf_dat_o` and clears `rf_empty` in cycle N+1.
- After a pop in cycle N, the next word is on `rf_dat_o` in cycle N+1.
- `rf_full` and `rf_count_o` are registered and update one cycle after the push/pop edge.
- Stop event: `fir_sto_detected` rising in cycle N (seen at edge N) makes the record visible with `st_valid`=1 in cycle N+1.
- Overrun flags assert in the cycle after the offending push or event.
- No combinational path from any input to any output, except the head-data mux from the registered pointer.

## Configuration
- `IRDA_FIR_RX_STATUS_EN` defined: status queue, stop-event edge detector and frame word counter are built as described.
- Not defined: none of these are built. `st_valid`, `st_len_o`, `st_words_o`, `st_crc_err_o` and `st_overrun` are tied to 0, and `st_pop` is ignored. Data FIFO behaviour is unchanged.

## Test plan
- Reset, then push 3 words (0x11111111, 0x22222222, 0x33333333) on consecutive clocks, then pop 3 → `rf_dat_o` shows them in order; `rf_count_o` goes 1,2,3 then 2,1,0; `rf_empty`=1 at the end.
- Push 17 words with RF_AW=4 → `rf_full`=1 after the 16th; the 17th is dropped; `rf_overrun`=1; the popped sequence is words 1..16; `rf_flush` clears the overrun.
- With the FIFO full, push and pop in the same cycle → count stays 16, no overrun, new word at the tail.
- 5 pushes, then `fir_sto_detected` held 8 clocks with `fir_ifdlr_i`=0x0014, `crc32_error`=0 → exactly one record {0x0014, 5, 0}; the word counter restarts at 0 for the next frame.
- 5 stop events with ST_AW=2 and no `st_pop` → 4 records kept, `st_overrun`=1, the 5th record is lost; 4 `st_pop` → `st_valid`=0.
- Assert `wb_rst_i` mid-frame with 6 words queued → next cycle all outputs at reset values; following pushes start at the empty state.
